// File: rtl/expipe_pkg.sv
// Execution-pipeline types: ROB index, exception codes and divider op encodings.
package expipe_pkg;
  localparam int DIV_CTL_LEN  = 4;
  localparam int ROB_IDX_LEN  = 4;
  localparam int EXCEPT_CODE_LEN = 5;

  typedef logic [ROB_IDX_LEN-1:0]     rob_idx_t;
  typedef logic [EXCEPT_CODE_LEN-1:0] except_code_t;

  typedef enum logic [DIV_CTL_LEN-1:0] {
    OP_DIV   = 4'd0,
    OP_DIVU  = 4'd1,
    OP_REM   = 4'd2,
    OP_REMU  = 4'd3,
    OP_DIVW  = 4'd4,
    OP_DIVUW = 4'd5,
    OP_REMW  = 4'd6,
    OP_REMUW = 4'd7
  } div_ctl_t;
endpackage

// File: rtl/len5_pkg.sv
// Core-wide width parameters shared by every execution unit.
package len5_pkg;
  localparam int XLEN = 64;
endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it did not borrow.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted  = {rem, dvd_msb};
  assign diff     = shifted - {1'b0, divisor};
  // Partial remainder stays below the divisor, so bit W of diff is a clean borrow flag.
  assign q_bit    = ~diff[W];
  assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/iter_div.sv
// Iterative integer divider for the RV64M DIV/REM family: one quotient bit per
// cycle on magnitudes, sign fix-up on the final step, zero/overflow short-cut.
module iter_div
  import expipe_pkg::*;
#(
  parameter int EU_CTL_LEN = 4,
  parameter int XLEN       = len5_pkg::XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [EU_CTL_LEN-1:0] ctl_i,
  input  rob_idx_t              rob_idx_i,
  input  logic [XLEN-1:0]       rs1_value_i,
  input  logic [XLEN-1:0]       rs2_value_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output rob_idx_t              rob_idx_o,
  output logic [XLEN-1:0]       result_o,
  output logic                  except_raised_o,
  output except_code_t          except_code_o
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_W    = CNT_W'(31);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] wsext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  state_t state, state_next;

  // Handshakes: a request transfers on a rising edge where valid_i && ready_o;
  // a result transfers on a rising edge where valid_o && ready_i. ready_o is
  // high only in IDLE and valid_o only in DONE, so the two never overlap.
  logic accept;
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign accept  = valid_i && ready_o;

  div_ctl_t        op;
  logic            is_w, is_signed, is_rem;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_val, special_res;
  logic            sign_a, sign_b, div_zero, ovf, special;

  assign op        = div_ctl_t'(ctl_i[DIV_CTL_LEN-1:0]);
  assign is_w      = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  assign is_signed = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  assign is_rem    = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};

  // W ops see only the low word, extended according to signedness.
  assign a_ext = is_w ? (is_signed ? wsext(1'b1, rs1_value_i)
                                   : {{(XLEN-32){1'b0}}, rs1_value_i[31:0]})
                      : rs1_value_i;
  assign b_ext = is_w ? (is_signed ? wsext(1'b1, rs2_value_i)
                                   : {{(XLEN-32){1'b0}}, rs2_value_i[31:0]})
                      : rs2_value_i;

  assign sign_a  = is_signed & a_ext[XLEN-1];
  assign sign_b  = is_signed & b_ext[XLEN-1];
  assign abs_a   = sign_a ? -a_ext : a_ext;
  assign abs_b   = sign_b ? -b_ext : b_ext;
  assign min_val = is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = (b_ext == '0);
  assign ovf      = is_signed && (a_ext == min_val) && (b_ext == '1);
  assign special  = div_zero || ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = is_rem ? wsext(is_w, a_ext) : '1;
    else if (ovf) special_res = is_rem ? '0 : a_ext;
  end

  logic [XLEN-1:0]  rem_q, dvd_q, divisor_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_w_q, is_rem_q, q_neg_q, r_neg_q;
  rob_idx_t         rob_idx_q;

  logic [XLEN-1:0] step_rem, quot_next, q_val, r_val, final_res;
  logic            step_q, last_step;

  div_step #(.W(XLEN)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[XLEN-1]),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // dvd_q doubles as the quotient: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  assign quot_next = {dvd_q[XLEN-2:0], step_q};
  assign last_step = (cnt_q == (is_w_q ? LAST_W : LAST_FULL));
  assign q_val     = q_neg_q ? -quot_next : quot_next;
  assign r_val     = r_neg_q ? -step_rem : step_rem;
  assign final_res = wsext(is_w_q, is_rem_q ? r_val : q_val);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      is_w_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rob_idx_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rob_idx_q <= rob_idx_i;
          is_w_q    <= is_w;
          is_rem_q  <= is_rem;
          q_neg_q   <= sign_a ^ sign_b;
          r_neg_q   <= sign_a;
          divisor_q <= abs_b;
          dvd_q     <= is_w ? {abs_a[XLEN-33:0], 32'b0} : abs_a;
          rem_q     <= '0;
          cnt_q     <= '0;
          if (special) result_q <= special_res;
        end
        BUSY: begin
          rem_q <= step_rem;
          dvd_q <= quot_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign result_o        = result_q;
  assign rob_idx_o       = rob_idx_q;
  assign except_raised_o = 1'b0;
  assign except_code_o   = '0;
endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter EU_CTL_LEN, default 4, width of the operation control field.
REQ-002 SHALL have parameter XLEN, default len5_pkg::XLEN (64), operand/result width.
REQ-003 SHALL have port clk_i  in  1  clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  in  1  synchronous pipeline flush.
REQ-006 SHALL have ports valid_i in 1 and ready_o out 1: request handshake from the reservation station.
REQ-007 SHALL have ports ctl_i in EU_CTL_LEN, rob_idx_i in rob_idx_t, rs1_value_i in XLEN (dividend), rs2_value_i in XLEN (divisor).
REQ-008 SHALL have ports valid_o out 1 and ready_i in 1: result handshake back to the reservation station.
REQ-009 SHALL have ports rob_idx_o out rob_idx_t, result_o out XLEN, except_raised_o out 1, except_code_o out except_code_t.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = 1 only in IDLE.
REQ-011 SHALL accept a request when valid_i && ready_o, latching ctl, rob_idx, |dividend|, |divisor| and result signs.
REQ-012 SHALL support ops DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW encoded as div_ctl_t.
REQ-013 SHALL for W ops use bits [31:0] of the operands and sign-extend the 32-bit result to XLEN.
REQ-014 SHALL use restoring radix-2 division, one quotient bit per BUSY cycle; iterations N = XLEN for full-width ops, 32 for W ops.
REQ-015 SHALL go IDLE->BUSY on a normal accept, BUSY->DONE after exactly N BUSY cycles, DONE->IDLE when ready_i = 1.
REQ-016 SHALL assert valid_o exactly N+1 cycles after the accepting edge for normal ops.
REQ-017 SHALL detect divide-by-zero (divisor = 0) at accept and go IDLE->DONE: quotient all-ones, remainder = dividend; valid_o 1 cycle after accept.
REQ-018 SHALL detect signed overflow (dividend = most negative, divisor = -1) at accept and go IDLE->DONE: quotient = dividend, remainder 0.
REQ-019 SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend (signed ops only).
REQ-020 SHALL hold result_o, rob_idx_o and valid_o stable in DONE until ready_i = 1.
REQ-021 SHALL drive except_raised_o = 0 and except_code_o = 0 always.
REQ-022 SHALL on flush_i go to IDLE next cycle from any state, deassert valid_o, and discard the current operation.
REQ-023 SHALL give flush_i priority over a same-cycle accept (request dropped) and over a same-cycle DONE handshake.
REQ-024 SHALL not accept a new request in the DONE->IDLE handoff cycle (no back-to-back accept while ready_i is consumed).

Reset
REQ-025 SHALL on rst_i go to IDLE with valid_o = 0, result_o = 0, rob_idx_o = 0, iteration counter = 0, regardless of state.
REQ-026 SHALL give rst_i priority over flush_i and over any handshake in the same cycle.

Structure
REQ-027 SHALL take div_ctl_t op encodings, rob_idx_t and except_code_t from expipe_pkg, and XLEN from len5_pkg.
REQ-028 SHALL keep the FSM state enum local to the module.
REQ-029 SHALL place one combinational restoring step (shift, trial subtract, quotient bit) in sub-module div_step.

Verification
REQ-030 SHALL cover DIVU 100 / 7, rob_idx 3, ready_i held 1 -> valid_o at accept+65, result 14, rob_idx_o 3, ready_o 1 one cycle later.
REQ-031 SHALL cover REMW rs1 = 0x0000_0000_FFFF_FFF9 (-7), rs2 = 2 -> valid_o at accept+33, result 0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-032 SHALL cover DIV x / 0 and DIV 0x8000_0000_0000_0000 / -1 -> valid_o at accept+1, results all-ones and 0x8000_0000_0000_0000.
REQ-033 SHALL cover ready_i held 0 for 10 cycles in DONE -> valid_o, result_o, rob_idx_o unchanged, ready_o 0 throughout.
REQ-034 SHALL cover flush_i at BUSY cycle 20, and flush_i with valid_i in IDLE -> IDLE next cycle, valid_o never asserted, next request divides correctly.
REQ-035 SHALL cover rst_i asserted in BUSY -> IDLE next cycle, all outputs at reset values, ready_o 1.
